// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply unit: ALUcnt codes, FSM states,
// operation classes and the code-to-class decoder.
package hilo_pkg;

  localparam logic [5:0] ALU_MUL   = 6'b000010;
  localparam logic [5:0] ALU_MULT  = 6'b011000;
  localparam logic [5:0] ALU_MULTU = 6'b000011;
  localparam logic [5:0] ALU_MADD  = 6'b000100;
  localparam logic [5:0] ALU_MSUB  = 6'b000101;
  localparam logic [5:0] ALU_MTHI  = 6'b010100;
  localparam logic [5:0] ALU_MTLO  = 6'b010101;
  localparam logic [5:0] ALU_MFHI  = 6'b010110;
  localparam logic [5:0] ALU_MFLO  = 6'b010111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_MOVE  = 3'd0,
    OP_MULS  = 3'd1,
    OP_MULU  = 3'd2,
    OP_MACC  = 3'd3,
    OP_MSUB  = 3'd4,
    OP_OTHER = 3'd5
  } op_class_t;

  function automatic op_class_t classifyOp(input logic [5:0] code);
    op_class_t cls;
    case (code)
      ALU_MUL, ALU_MULT:                      cls = OP_MULS;
      ALU_MULTU:                              cls = OP_MULU;
      ALU_MADD:                               cls = OP_MACC;
      ALU_MSUB:                               cls = OP_MSUB;
      ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO: cls = OP_MOVE;
      default:                                cls = OP_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Iterative shift-add magnitude multiplier: retires STEP multiplier bits per
// cycle and pulses finish during its last iteration.
module mul_iter_core
  import hilo_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signedOp,
  output logic [63:0] product,
  output logic        finish
);

  localparam int N  = 32 / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [32:0]   aExt, bExt, magA, magB;
  logic [63:0]   mcand, acc, partial;
  logic [32:0]   mplier;
  logic [CW-1:0] count;
  logic          running;

  // 33-bit sign extension so that |0x80000000| = 2^31 is representable
  always_comb begin
    aExt = signedOp ? {a[31], a} : {1'b0, a};
    bExt = signedOp ? {b[31], b} : {1'b0, b};
    magA = aExt[32] ? (33'd0 - aExt) : aExt;
    magB = bExt[32] ? (33'd0 - bExt) : bExt;
  end

  always_comb begin
    partial = '0;
    for (int j = 0; j < STEP; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {31'd0, magA};
      mplier  <= magB;
      acc     <= '0;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc + partial;
      mcand  <= mcand << STEP;
      mplier <= mplier >> STEP;
      count  <= count + CW'(1);
      if (count == CW'(N - 1)) running <= 1'b0;
    end
  end

  assign finish  = running && (count == CW'(N - 1));
  assign product = acc;

endmodule

// File: rtl/hilo_mul_unit.sv
// HI/LO execute unit: owns HI and LO, sequences multiplies through the
// iterative core and applies MULT/MADD/MSUB/MUL results in the ACC state.
module hilo_mul_unit
  import hilo_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        in_valid,
  input  logic [5:0]  ALUcnt,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_t    state, nextState;
  op_class_t reqClass, accClass;
  logic [5:0]  opReg;
  logic        negFlag;
  logic        accept, isMultiply, startMul, mulFinish;
  logic [63:0] product, finalProd, hiloSum, hiloDiff;

  assign reqClass   = classifyOp(ALUcnt);
  assign accClass   = classifyOp(opReg);
  assign isMultiply = (reqClass == OP_MULS) || (reqClass == OP_MULU) ||
                      (reqClass == OP_MACC) || (reqClass == OP_MSUB);
  assign accept     = in_valid && (state == S_IDLE);
  assign startMul   = accept && isMultiply;

  mul_iter_core #(.STEP(STEP)) core (
    .clk      (Clk),
    .reset    (Reset),
    .start    (startMul),
    .a        (A),
    .b        (B),
    .signedOp (reqClass != OP_MULU),
    .product  (product),
    .finish   (mulFinish)
  );

  assign finalProd = negFlag ? (64'd0 - product) : product;
  assign hiloSum   = {HI, LO} + finalProd;
  assign hiloDiff  = {HI, LO} - finalProd;

  always_comb begin
    nextState = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    case (state)
      S_IDLE: if (accept) nextState = isMultiply ? S_MUL : S_DONE;
      S_MUL:  if (mulFinish) nextState = S_ACC;
      S_ACC:  nextState = S_DONE;
      S_DONE: nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // HI/LO are written either at a move accept (IDLE) or in ACC, never both
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      HI      <= '0;
      LO      <= '0;
      Result  <= '0;
      opReg   <= '0;
      negFlag <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        case (reqClass)
          OP_MOVE: begin
            case (ALUcnt)
              ALU_MTHI: begin HI <= A; Result <= '0; end
              ALU_MTLO: begin LO <= A; Result <= '0; end
              ALU_MFHI: Result <= HI;
              ALU_MFLO: Result <= LO;
              default:  Result <= '0;
            endcase
          end
          OP_OTHER: Result <= '0;
          default: begin
            opReg   <= ALUcnt;
            negFlag <= (reqClass != OP_MULU) && (A[31] ^ B[31]);
          end
        endcase
      end
      if (state == S_ACC) begin
        case (accClass)
          OP_MACC: begin {HI, LO} <= hiloSum;  Result <= '0; end
          OP_MSUB: begin {HI, LO} <= hiloDiff; Result <= '0; end
          OP_MULS: begin
            if (opReg == ALU_MUL) begin
              Result <= finalProd[31:0];
            end else begin
              {HI, LO} <= finalProd;
              Result   <= '0;
            end
          end
          default: begin {HI, LO} <= finalProd; Result <= '0; end
        endcase
      end
    end
  end

endmodule
